dmux4_sched: RTL and testbench
==============================

# dmux4_sched

Round-robin scheduler that shares a single input stream among four consumers by driving the select of the DMUX4Way 1-to-4 demultiplexer. Grants one consumer at a time for a fixed burst of beats and registers the data beat on its way out. Uses valid/ready handshakes on both sides. Sits directly upstream of a DMUX4Way instance: `sel` drives its `s`, `out_data` drives its `X`.

## Interface
- `DW`, 1: data width per beat (DMUX4Way path is 1 bit; wider for replicated demuxes).
- `BURST`, 4: beats accepted per grant; legal range 1..256.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  block accepts beat this cycle.
- `in_data`  in  DW  upstream beat.
- `out_ready`  in  4  per-consumer ready, bit i = OUT(i+1).
- `out_valid`  out  4  one-hot valid, equal to `1 << sel` while the output register is full, else 0.
- `out_data`  out  DW  registered beat, to DMUX4Way `X`.
- `sel`  out  2  granted consumer, to DMUX4Way `s`.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `sel`=0, `busy`=0. Round-robin pointer=0, beat count=0, state=IDLE.
- States: IDLE, BURST, DRAIN.
- **IDLE**
  - Search the consumers in order ptr, ptr+1, … mod 4.
  - The first consumer with `out_ready` high is granted g, but only when `in_valid`=1.
  - On grant: `sel`<=g, ptr<=(g+1) mod 4 (3 wraps to 0), count<=0, go to BURST.
  - With no ready consumer or no `in_valid`, stay in IDLE. `in_ready`=0 throughout IDLE.
- **BURST**
  - `in_ready` = !out_full || out_ready[sel].
  - Input accept (`in_valid`&&`in_ready`): the output register loads `in_data` and count increments.
  - Output transfer happens when out_full && out_ready[sel]. A simultaneous accept and transfer leaves the register full with the new beat.
  - After the BURST-th accept, go to DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - When the register is empty, or empties this cycle, go to IDLE.
- `sel` is constant from grant until the next IDLE grant. A consumer dropping `out_ready` mid-burst stalls the burst; the block never re-arbitrates or skips.
- Beat count width is $clog2(BURST+1). BURST=1 goes BURST→DRAIN on the first accept.
- Reset mid-burst: all state returns to reset values immediately, the in-flight beat is dropped, and `out_valid` falls asynchronously.

## Timing
- Grant decision in IDLE at cycle t: `sel`/`busy` update at t+1. The first beat can be accepted at t+1.
- Input-to-output latency is 1 cycle: a beat accepted at cycle n is on `out_data` with `out_valid` at n+1.
- Full throughput: one beat per cycle while `out_ready[sel]` stays high.
- Minimum grant-to-grant period is BURST+2 cycles: IDLE cycle, BURST beats, then the final beat drains in the cycle the state returns to IDLE.
- `in_ready` is combinational from `out_ready` and state. `out_valid`, `out_data` and `sel` are registered.

## Configuration
- `DMUX4_SCHED_STATS_EN` defined:
  - Adds output port `stat_beats`, 4×16 bits.
  - Each entry counts output transfers to that consumer and wraps at 16 bits.
  - Reset value is 0.
- Not defined: the port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package `dmux4_pkg`:
  - `sel_t` (logic [1:0])
  - state enum `sched_state_t` {IDLE, BURST, DRAIN}
  - constant `NUM_OUT`=4
- Sub-module `dmux4_rr_pick`: combinational rotate-priority picker.
  - Inputs: 4-bit request, 2-bit pointer.
  - Outputs: 2-bit grant index, grant valid.
- The FSM, output register, counters and stats live in `dmux4_sched`.

## Test plan
- Reset then release, all `out_ready`=1, `in_valid`=1, BURST=4:
  - Grants in order 0,1,2,3,0.
  - Each grant gets exactly 4 beats on `out_valid` one-hot 0001, 0010, 0100, 1000.
- `out_ready`=4'b0100 only, pointer=0: the grant skips to `sel`=2 and ptr becomes 3. The next grant with `out_ready`=4'b0001 goes to `sel`=0 (3→0 wrap).
- Mid-burst, drop `out_ready[sel]` for 3 cycles:
  - `in_ready`=0 and `out_valid` is held with `out_data` unchanged.
  - `sel` does not change.
  - The burst resumes and totals 4 beats.
- Incrementing `in_data` 0..15 with `DW`=4, continuous ready: every beat appears exactly 1 cycle after acceptance, with no loss or duplication.
- Assert `rst_n`=0 while the output register is full in BURST: `out_valid`=0 and `sel`=0 immediately, and after release the first grant goes to consumer 0.
- With `DMUX4_SCHED_STATS_EN`, run 3 full rounds: `stat_beats`=12 for each consumer.

Source files
------------

// File: rtl/dmux4_pkg.sv
// Shared types and constants for the dmux4_sched round-robin scheduler.
package dmux4_pkg;

    localparam int NUM_OUT = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // One-hot consumer valid pattern for a given select value.
    function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_t s);
        sel_onehot = 4'b0001 << s;
    endfunction

endpackage

// File: rtl/dmux4_rr_pick.sv
// Combinational rotate-priority picker: searches req starting at ptr,
// wrapping mod 4, and returns the first requesting index.
module dmux4_rr_pick
    import dmux4_pkg::*;
(
    input  logic [NUM_OUT-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         grant,
    output logic               grant_vld
);

    logic [2*NUM_OUT-1:0] dbl_s;
    logic [NUM_OUT-1:0]   rot_s;
    sel_t                 off_s;

    // Rotate the request vector so bit 0 is the pointer position, then pick the lowest set bit.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[NUM_OUT-1:0];
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: off_s = 2'd0;
        endcase
        grant     = ptr + off_s;
        grant_vld = |rot_s;
    end

endmodule

// File: rtl/dmux4_sched.sv
// Round-robin scheduler driving the select of a DMUX4Way demultiplexer.
// Grants one consumer per BURST beats and registers each beat on its way out.
// Optional feature macro: DMUX4_SCHED_STATS_EN adds per-consumer transfer
// counters on port stat_beats.
module dmux4_sched
    import dmux4_pkg::*;
#(
    parameter int DW    = 1,
    parameter int BURST = 4
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DW-1:0]      out_data,
    output logic [1:0]         sel,
    output logic               busy
`ifdef DMUX4_SCHED_STATS_EN
    ,
    output logic [NUM_OUT-1:0][15:0] stat_beats
`endif
);

    localparam int CW = $clog2(BURST + 1);

    sched_state_t       state_r;
    sel_t               sel_r;
    sel_t               ptr_r;
    logic [CW-1:0]      count_r;
    logic [NUM_OUT-1:0] out_valid_r;
    logic [DW-1:0]      out_data_r;
    logic               busy_r;

    logic               out_full_s;
    logic               xfer_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               last_s;
    logic [1:0]         pick_idx_s;
    logic               pick_vld_s;

    dmux4_rr_pick u_pick (
        .req       (out_ready),
        .ptr       (ptr_r),
        .grant     (pick_idx_s),
        .grant_vld (pick_vld_s)
    );

    // Handshake decode; out_valid_r only ever has the sel_r bit set, so the AND is the transfer.
    always_comb begin
        out_full_s = |out_valid_r;
        xfer_s     = |(out_valid_r & out_ready);
        case (state_r)
            ST_BURST: in_ready_s = !out_full_s || out_ready[sel_r];
            default:  in_ready_s = 1'b0;
        endcase
        accept_s = in_valid && in_ready_s;
        last_s   = (count_r == CW'(BURST - 1));
    end

    // Scheduler FSM with the output beat register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= 2'd0;
            ptr_r       <= 2'd0;
            count_r     <= '0;
            out_valid_r <= 4'b0000;
            out_data_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && pick_vld_s) begin
                        sel_r   <= pick_idx_s;
                        ptr_r   <= pick_idx_s + 2'd1;
                        count_r <= '0;
                        busy_r  <= 1'b1;
                        state_r <= ST_BURST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (accept_s) begin
                        // A simultaneous transfer is covered: the register simply refills.
                        out_data_r  <= in_data;
                        out_valid_r <= sel_onehot(sel_r);
                        count_r     <= count_r + CW'(1);
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_BURST;
                        end
                    end else if (xfer_s) begin
                        out_valid_r <= 4'b0000;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
                ST_DRAIN: begin
                    if (!out_full_s || xfer_s) begin
                        out_valid_r <= 4'b0000;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 4'b0000;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMUX4_SCHED_STATS_EN
    logic [NUM_OUT-1:0][15:0] stat_r;

    // Per-consumer output transfer counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_r <= '0;
        end else if (xfer_s) begin
            stat_r[sel_r] <= stat_r[sel_r] + 16'd1;
        end else begin
            stat_r <= stat_r;
        end
    end

    assign stat_beats = stat_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign sel       = sel_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmux4_sched.sv
// Directed self-checking bench for dmux4_sched (DW=4, BURST=4).
module tb_dmux4_sched;
    localparam int TDW = 4;
    localparam int TB  = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [TDW-1:0] in_data;
    logic [3:0]     out_ready;
    logic [3:0]     out_valid;
    logic [TDW-1:0] out_data;
    logic [1:0]     sel;
    logic           busy;
`ifdef DMUX4_SCHED_STATS_EN
    logic [3:0][15:0] stat_beats;
`endif

    dmux4_sched #(.DW(TDW), .BURST(TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .busy      (busy)
`ifdef DMUX4_SCHED_STATS_EN
        ,
        .stat_beats(stat_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_acc = 0;
    int n_xf  = 0;
    logic last_acc;
    logic last_xfer;

    logic [TDW-1:0] acc_d[$];
    int             acc_c[$];
    logic [TDW-1:0] xf_d[$];
    logic [3:0]     xf_v[$];
    int             xf_c[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sample handshakes at negedge, advance one clock, bump data after an accept.
    task automatic tick();
        @(negedge clk);
        last_acc  = in_valid && in_ready;
        last_xfer = |(out_valid & out_ready);
        if (last_acc) begin
            acc_d.push_back(in_data);
            acc_c.push_back(cyc);
            n_acc++;
        end
        if (last_xfer) begin
            xf_d.push_back(out_data);
            xf_v.push_back(out_valid);
            xf_c.push_back(cyc);
            n_xf++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (last_acc) in_data = in_data + 4'd1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        in_data   = 4'd0;
        rst_n     = 1'b0;
        #1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One full grant: arbitration, BURST accepts, drain back to idle.
    task automatic do_grant(input logic [3:0] mask, input logic [1:0] exp_sel, input string tag);
        bit done;
        out_ready = mask;
        in_valid  = 1'b1;
        n_acc = 0;
        n_xf  = 0;
        tick();
        chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (n_acc == TB) begin
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        chk({tag, "_acc"}, 32'(n_acc), 32'(TB));
        chk({tag, "_xfers"}, 32'(n_xf), 32'(TB));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [TDW-1:0] held_d;
        bit done;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Round robin with everyone ready: grants 0,1,2,3,0, 4 beats each, data 0..19 mod 16
        do_reset();
        acc_d.delete(); acc_c.delete(); xf_d.delete(); xf_v.delete(); xf_c.delete();
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            tick();
            if (acc_d.size() == 20) begin
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
        repeat (3) tick();
        chk("rr_acc_count", 32'(acc_d.size()), 32'd20);
        chk("rr_xfer_count", 32'(xf_d.size()), 32'd20);
        if (acc_d.size() == 20 && xf_d.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk($sformatf("rr_onehot%0d", i), 32'(xf_v[i]), 32'(4'b0001 << ((i / 4) % 4)));
                chk($sformatf("rr_data%0d", i), 32'(xf_d[i]), 32'(i % 16));
                chk($sformatf("rr_lat%0d", i), 32'(xf_c[i] - acc_c[i]), 32'd1);
                chk($sformatf("rr_acc_cyc%0d", i), 32'(acc_c[i] - acc_c[0]),
                    32'(6 * (i / 4) + (i % 4)));
            end
        end
        chk("rr_end_busy", 32'(busy), 32'd0);
        chk("rr_end_valid", 32'(out_valid), 32'd0);

        // Pointer skip and wrap
        do_reset();
        do_grant(4'b0100, 2'd2, "skip_to2");
        do_grant(4'b0001, 2'd0, "wrap3_to0");
        do_grant(4'b1001, 2'd3, "ptr1_to3");
        do_grant(4'b1111, 2'd0, "ptr_wrapped0");

        // Mid-burst stall: ptr is 1 now
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        n_acc = 0;
        n_xf  = 0;
        tick();
        chk("stall_sel", 32'(sel), 32'd1);
        tick();
        tick();
        out_ready = 4'b1101;
        #1;
        held_d = out_data;
        chk("stall_in_ready0", 32'(in_ready), 32'd0);
        chk("stall_valid0", 32'(out_valid), 32'(4'b0010));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_in_ready%0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("stall_valid%0d", i), 32'(out_valid), 32'(4'b0010));
            chk($sformatf("stall_data%0d", i), 32'(out_data), 32'(held_d));
            chk($sformatf("stall_sel%0d", i), 32'(sel), 32'd1);
        end
        out_ready = 4'b1111;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (n_acc == TB) begin
                in_valid = 1'b0;
                done = 1'b1;
            end
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("stall_total_acc", 32'(n_acc), 32'd4);
        chk("stall_total_xfer", 32'(n_xf), 32'd4);

        // Reset while the output register is full: ptr is 2 here
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        tick();
        chk("mid_rst_sel", 32'(sel), 32'd2);
        tick();
        chk("mid_rst_full", 32'(out_valid), 32'(4'b0100));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_sel0", 32'(sel), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_grant(4'b1111, 2'd0, "after_rst");

`ifdef DMUX4_SCHED_STATS_EN
        // Three full rounds: 12 beats per consumer
        do_reset();
        for (int i = 0; i < 12; i++) do_grant(4'b1111, 2'(i % 4), $sformatf("stat_g%0d", i));
        for (int i = 0; i < 4; i++) chk($sformatf("stat_beats%0d", i), 32'(stat_beats[i]), 32'd12);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
